mem_port_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single shared instruction/data memory of the multi-cycle RISC-V core. It lets the core controller's memory port (instruction fetch, `lw`, `sw`) and the program loader/debug port take turns on one fixed-latency synchronous memory. The block uses round-robin fairness, a req/gnt/valid handshake per port, and a wait-state counter that holds the memory access for `MEM_LAT` cycles. It sits between the core datapath's address mux and the memory macro.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and wait-state sequencer sharing one fixed-latency synchronous memory
// between the core memory port and the loader/debug port.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // core port
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_adr_i,
    input  logic [DW-1:0] c_wd_i,
    output logic          c_gnt_o,
    output logic          c_valid_o,
    output logic [DW-1:0] c_rd_o,
    // loader port
    input  logic          l_req_i,
    input  logic          l_we_i,
    input  logic [AW-1:0] l_adr_i,
    input  logic [DW-1:0] l_wd_i,
    output logic          l_gnt_o,
    output logic          l_valid_o,
    output logic [DW-1:0] l_rd_o,
    // memory side
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam logic       OwnCore   = 1'b0;
    localparam logic       OwnLoader = 1'b1;
    localparam logic [3:0] CntLoad   = 4'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          c_gnt_q, c_gnt_d;
    logic          l_gnt_q, l_gnt_d;
    logic [DW-1:0] c_rd_q, c_rd_d;
    logic [DW-1:0] l_rd_q, l_rd_d;
    logic          pick_loader;

    // Loader wins when it is the only requester, or on a tie when the core went last.
    assign pick_loader = l_req_i && (!c_req_i || (last_q == OwnCore));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wd_d    = wd_q;
        c_gnt_d = 1'b0;
        l_gnt_d = 1'b0;
        c_rd_d  = c_rd_q;
        l_rd_d  = l_rd_q;

        case (state_q)
            StIdle: begin
                if (c_req_i || l_req_i) begin
                    owner_d = pick_loader;
                    we_d    = pick_loader ? l_we_i  : c_we_i;
                    adr_d   = pick_loader ? l_adr_i : c_adr_i;
                    wd_d    = pick_loader ? l_wd_i  : c_wd_i;
                    cnt_d   = CntLoad;
                    c_gnt_d = !pick_loader;
                    l_gnt_d = pick_loader;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q == OwnLoader) begin
                            l_rd_d = mem_rd_i;
                        end else begin
                            c_rd_d = mem_rd_i;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            last_q  <= OwnLoader;
            owner_q <= OwnCore;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wd_q    <= '0;
            c_gnt_q <= 1'b0;
            l_gnt_q <= 1'b0;
            c_rd_q  <= '0;
            l_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            c_gnt_q <= c_gnt_d;
            l_gnt_q <= l_gnt_d;
            c_rd_q  <= c_rd_d;
            l_rd_q  <= l_rd_d;
        end
    end

    // Enables decode from state so an asynchronous reset drops them without a clock.
    always_comb begin
        mem_en_o  = (state_q == StAccess);
        mem_we_o  = (state_q == StAccess) && we_q;
        mem_adr_o = adr_q;
        mem_wd_o  = wd_q;
        c_valid_o = (state_q == StResp) && (owner_q == OwnCore);
        l_valid_o = (state_q == StResp) && (owner_q == OwnLoader);
        c_gnt_o   = c_gnt_q;
        l_gnt_o   = l_gnt_q;
        c_rd_o    = c_rd_q;
        l_rd_o    = l_rd_q;
        busy_o    = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance checked through a completion
// scoreboard plus cycle checks, and a MEM_LAT=1 instance for single-cycle access.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // MEM_LAT = 2 instance
    logic        c_req, c_we, c_gnt, c_valid;
    logic [31:0] c_adr, c_wd, c_rd;
    logic        l_req, l_we, l_gnt, l_valid;
    logic [31:0] l_adr, l_wd, l_rd;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_adr, mem_wd, mem_rd;

    // MEM_LAT = 1 instance
    logic        c_req1, c_gnt1, c_valid1, l_gnt1, l_valid1;
    logic [31:0] c_adr1, c_rd1, l_rd1;
    logic        mem_en1, mem_we1, busy1;
    logic [31:0] mem_adr1, mem_wd1, mem_rd1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        port;  // 0 core, 1 loader
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    assign mem_rd  = rd_val(mem_adr);
    assign mem_rd1 = rd_val(mem_adr1);

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .c_req_i(c_req), .c_we_i(c_we), .c_adr_i(c_adr), .c_wd_i(c_wd),
        .c_gnt_o(c_gnt), .c_valid_o(c_valid), .c_rd_o(c_rd),
        .l_req_i(l_req), .l_we_i(l_we), .l_adr_i(l_adr), .l_wd_i(l_wd),
        .l_gnt_o(l_gnt), .l_valid_o(l_valid), .l_rd_o(l_rd),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_adr_o(mem_adr), .mem_wd_o(mem_wd),
        .mem_rd_i(mem_rd), .busy_o(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .c_req_i(c_req1), .c_we_i(1'b0), .c_adr_i(c_adr1), .c_wd_i(32'h0),
        .c_gnt_o(c_gnt1), .c_valid_o(c_valid1), .c_rd_o(c_rd1),
        .l_req_i(1'b0), .l_we_i(1'b0), .l_adr_i(32'h0), .l_wd_i(32'h0),
        .l_gnt_o(l_gnt1), .l_valid_o(l_valid1), .l_rd_o(l_rd1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_adr_o(mem_adr1), .mem_wd_o(mem_wd1),
        .mem_rd_i(mem_rd1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every valid pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (c_gnt || l_gnt) chk("gnt_exclusive", {31'b0, c_gnt & l_gnt}, 32'h0);
        if (c_valid || l_valid) begin
            chk("valid_exclusive", {31'b0, c_valid & l_valid}, 32'h0);
            tests++;
            assert (sb.size() != 0)
            else begin
                fails++;
                $error("FAIL sb_unexpected_valid: observed=c%0b/l%0b expected=none",
                       c_valid, l_valid);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_port", {31'b0, l_valid}, {31'b0, e.port});
                chk("valid_rd", e.port ? l_rd : c_rd, e.rd);
            end
        end
    end

    initial begin
        logic [31:0] exp_c_rd;
        logic [31:0] exp_l_rd;
        c_req = 0; c_we = 0; c_adr = 0; c_wd = 0;
        l_req = 0; l_we = 0; l_adr = 0; l_wd = 0;
        c_req1 = 0; c_adr1 = 0;
        exp_c_rd = 0; exp_l_rd = 0;
        #1 rst_n = 1'b0;
        step();
        chk("rst_c_gnt", {31'b0, c_gnt}, 32'h0);
        chk("rst_l_gnt", {31'b0, l_gnt}, 32'h0);
        chk("rst_c_valid", {31'b0, c_valid}, 32'h0);
        chk("rst_l_valid", {31'b0, l_valid}, 32'h0);
        chk("rst_c_rd", c_rd, 32'h0);
        chk("rst_l_rd", l_rd, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        step();
        rst_n = 1'b1;

        // Reset in the second ACCESS cycle aborts the read; no completion is pushed.
        c_req = 1; c_adr = 32'h10;
        step();
        chk("abort_c_gnt", {31'b0, c_gnt}, 32'h1);
        chk("abort_mem_en_c1", {31'b0, mem_en}, 32'h1);
        c_req = 0;
        step();
        chk("abort_mem_en_c2", {31'b0, mem_en}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_en_async", {31'b0, mem_en}, 32'h0);
        chk("abort_busy_async", {31'b0, busy}, 32'h0);
        chk("abort_mem_adr_async", mem_adr, 32'h0);
        step();
        chk("abort_no_c_valid", {31'b0, c_valid}, 32'h0);
        rst_n = 1'b1;

        // Core read of 0x10 alone.
        c_req = 1; c_adr = 32'h10;
        exp_c_rd = rd_val(32'h10);
        sb.push_back('{port: 1'b0, rd: exp_c_rd});
        step();
        chk("crd_c_gnt", {31'b0, c_gnt}, 32'h1);
        chk("crd_l_gnt", {31'b0, l_gnt}, 32'h0);
        chk("crd_mem_en_c1", {31'b0, mem_en}, 32'h1);
        chk("crd_mem_adr_c1", mem_adr, 32'h10);
        chk("crd_mem_we_c1", {31'b0, mem_we}, 32'h0);
        chk("crd_busy_c1", {31'b0, busy}, 32'h1);
        c_req = 0;
        step();
        chk("crd_c_gnt_c2", {31'b0, c_gnt}, 32'h0);
        chk("crd_mem_en_c2", {31'b0, mem_en}, 32'h1);
        step();
        chk("crd_c_valid_c3", {31'b0, c_valid}, 32'h1);
        chk("crd_c_rd_c3", c_rd, 32'hDEAD_BEEF);
        chk("crd_mem_en_c3", {31'b0, mem_en}, 32'h0);
        chk("crd_l_valid", {31'b0, l_valid}, 32'h0);
        chk("crd_l_rd", l_rd, 32'h0);
        step();
        chk("crd_busy_c4", {31'b0, busy}, 32'h0);

        // Loader write of 0x1234 to 0x20; write data changed after the grant.
        l_req = 1; l_we = 1; l_adr = 32'h20; l_wd = 32'h1234;
        sb.push_back('{port: 1'b1, rd: exp_l_rd});
        step();
        chk("lwr_l_gnt", {31'b0, l_gnt}, 32'h1);
        chk("lwr_mem_we_c1", {31'b0, mem_we}, 32'h1);
        chk("lwr_mem_adr_c1", mem_adr, 32'h20);
        chk("lwr_mem_wd_c1", mem_wd, 32'h1234);
        l_req = 0; l_wd = 32'hFFFF; l_adr = 32'hFC;
        step();
        chk("lwr_mem_we_c2", {31'b0, mem_we}, 32'h1);
        chk("lwr_mem_adr_c2", mem_adr, 32'h20);
        chk("lwr_mem_wd_c2", mem_wd, 32'h1234);
        step();
        chk("lwr_l_valid_c3", {31'b0, l_valid}, 32'h1);
        chk("lwr_mem_we_c3", {31'b0, mem_we}, 32'h0);
        chk("lwr_l_rd", l_rd, exp_l_rd);
        chk("lwr_c_rd_kept", c_rd, exp_c_rd);
        step();
        l_we = 0;

        // Later core read of 0x8.
        c_req = 1; c_adr = 32'h8;
        exp_c_rd = rd_val(32'h8);
        sb.push_back('{port: 1'b0, rd: exp_c_rd});
        step();
        chk("crd2_c_gnt", {31'b0, c_gnt}, 32'h1);
        c_req = 0;
        step();
        step();
        chk("crd2_c_rd", c_rd, 32'hC0DE_0008);
        step();

        // Continuous dual requests from reset: C, L, C, L spaced by 4 cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("dual_c_rd_reset", c_rd, 32'h0);
        c_adr = 32'h30; l_adr = 32'h40; c_req = 1; l_req = 1;
        exp_c_rd = rd_val(32'h30);
        exp_l_rd = rd_val(32'h40);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{port: 1'b0, rd: exp_c_rd});
            sb.push_back('{port: 1'b1, rd: exp_l_rd});
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("dual_c_gnt_%0d", k), {31'b0, c_gnt},
                {31'b0, (k == 1 || k == 9)});
            chk($sformatf("dual_l_gnt_%0d", k), {31'b0, l_gnt},
                {31'b0, (k == 5 || k == 13)});
            chk($sformatf("dual_mem_en_%0d", k), {31'b0, mem_en},
                {31'b0, (k % 4 == 1 || k % 4 == 2)});
            if (k == 13) begin
                c_req = 0;
                l_req = 0;
            end
        end
        chk("dual_busy_end", {31'b0, busy}, 32'h0);

        // Loader request raised during a core read waits; core address stays latched.
        c_req = 1; c_adr = 32'h50;
        sb.push_back('{port: 1'b0, rd: rd_val(32'h50)});
        step();
        chk("wait_c_gnt", {31'b0, c_gnt}, 32'h1);
        c_req = 0; c_adr = 32'h60; l_req = 1; l_adr = 32'h44;
        sb.push_back('{port: 1'b1, rd: rd_val(32'h44)});
        step();
        chk("wait_mem_adr_c2", mem_adr, 32'h50);
        chk("wait_l_gnt_c2", {31'b0, l_gnt}, 32'h0);
        step();
        chk("wait_c_valid_c3", {31'b0, c_valid}, 32'h1);
        chk("wait_c_rd_c3", c_rd, rd_val(32'h50));
        chk("wait_l_gnt_c3", {31'b0, l_gnt}, 32'h0);
        step();
        chk("wait_l_gnt_c4", {31'b0, l_gnt}, 32'h0);
        chk("wait_busy_c4", {31'b0, busy}, 32'h0);
        step();
        chk("wait_l_gnt_c5", {31'b0, l_gnt}, 32'h1);
        chk("wait_mem_adr_c5", mem_adr, 32'h44);
        l_req = 0;
        step();
        step();
        chk("wait_l_valid_c7", {31'b0, l_valid}, 32'h1);
        step();

        // MEM_LAT = 1: single ACCESS cycle, back-to-back reads of 0x0 and 0x4.
        c_req1 = 1; c_adr1 = 32'h0;
        step();
        chk("lat1_c_gnt_c1", {31'b0, c_gnt1}, 32'h1);
        chk("lat1_l_gnt_c1", {31'b0, l_gnt1}, 32'h0);
        chk("lat1_mem_en_c1", {31'b0, mem_en1}, 32'h1);
        chk("lat1_mem_we_c1", {31'b0, mem_we1}, 32'h0);
        c_req1 = 0;
        step();
        chk("lat1_mem_en_c2", {31'b0, mem_en1}, 32'h0);
        chk("lat1_c_valid_c2", {31'b0, c_valid1}, 32'h1);
        chk("lat1_c_rd_a", c_rd1, 32'hC0DE_0000);
        c_adr1 = 32'h4; c_req1 = 1;
        step();
        chk("lat1_busy_c3", {31'b0, busy1}, 32'h0);
        step();
        chk("lat1_c_gnt_b", {31'b0, c_gnt1}, 32'h1);
        chk("lat1_mem_adr_b", mem_adr1, 32'h4);
        c_req1 = 0;
        step();
        chk("lat1_c_valid_b", {31'b0, c_valid1}, 32'h1);
        chk("lat1_c_rd_b", c_rd1, 32'hC0DE_0004);
        chk("lat1_l_valid", {31'b0, l_valid1}, 32'h0);
        chk("lat1_l_rd", l_rd1, 32'h0);
        chk("lat1_mem_wd", mem_wd1, 32'h0);
        step();

        chk("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
